// File: rtl/wb2uart_if.sv
// Bundles the Wishbone read-data handshake and UART transmitter signals of wb2uart.
interface wb2uart_if;
    logic [31:0] WB_i_data;
    logic        WB_i_ack;
    logic        UART_tx_busy;
    logic [7:0]  UART_out_data;
    logic        UART_tx_start;
    logic        WB_o_busy;
    logic        WB_o_overrun;

    modport master (
        output WB_i_data, WB_i_ack, UART_tx_busy,
        input  UART_out_data, UART_tx_start, WB_o_busy, WB_o_overrun
    );

    modport slave (
        input  WB_i_data, WB_i_ack, UART_tx_busy,
        output UART_out_data, UART_tx_start, WB_o_busy, WB_o_overrun
    );
endinterface

// File: rtl/wb2uart.sv
// Prints each acknowledged Wishbone word as lowercase hex ASCII over a UART transmitter.
// Define WB2UART_CRLF_EN to terminate each word with CR LF instead of a single space.
module wb2uart #(
    parameter int unsigned NIBBLES = 8
) (
    input  logic      clk,
    input  logic      rst,
    wb2uart_if.slave  bus
);

`ifdef WB2UART_CRLF_EN
    localparam int unsigned TERM_CHARS = 2;
`else
    localparam int unsigned TERM_CHARS = 1;
`endif
    localparam int unsigned NCHARS = NIBBLES + TERM_CHARS;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [2:0] {IDLE, PRE, SEND, GUARD, WAIT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       char_q, char_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h57 + 8'(n);
    endfunction

    // Character at position idx: nibbles MSB first, then the terminator.
    function automatic logic [7:0] char_at(input logic [IDX_W-1:0] idx,
                                           input logic [31:0] data);
        logic [4:0] sel;
        logic [3:0] nib;
        sel = 5'(NIBBLES - 1) - 5'(idx);
        nib = 4'(data >> {sel, 2'b00});
        if (5'(idx) < 5'(NIBBLES))
            return hex_char(nib);
`ifdef WB2UART_CRLF_EN
        else if (5'(idx) == 5'(NIBBLES))
            return 8'h0d;
        else
            return 8'h0a;
`else
        else
            return 8'h20;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            char_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // Output registers are loaded on the transition into SEND so they align with the SEND cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        char_d  = char_q;
        start_d = 1'b0;
        ovr_d   = bus.WB_i_ack && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.WB_i_ack) begin
                    data_d  = bus.WB_i_data;
                    idx_d   = '0;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (!bus.UART_tx_busy) begin
                    state_d = SEND;
                    char_d  = char_at(idx_q, data_q);
                    start_d = 1'b1;
                end
            end
            SEND:  state_d = GUARD;
            GUARD: state_d = WAIT;
            WAIT: begin
                if (!bus.UART_tx_busy) begin
                    if (32'(idx_q) + 32'd1 < NCHARS) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SEND;
                        char_d  = char_at(idx_d, data_q);
                        start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.UART_out_data = char_q;
    assign bus.UART_tx_start = start_q;
    assign bus.WB_o_busy     = busy_q;
    assign bus.WB_o_overrun  = ovr_q;

endmodule

// File: tb/tb_wb2uart.sv
// Directed bench for wb2uart: table of frames on NIBBLES=8 and NIBBLES=2 instances plus a reset-abort sequence.
module tb_wb2uart;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb2uart_if b8();
    wb2uart_if b2();

    wb2uart #(.NIBBLES(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    wb2uart #(.NIBBLES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

`ifdef WB2UART_CRLF_EN
    localparam int TERM_N = 2;
`else
    localparam int TERM_N = 1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          sel;          // 0: NIBBLES=8 instance, 1: NIBBLES=2 instance
        int          nib;
        logic [31:0] word;
        logic [63:0] hex;          // expected digits, right-aligned ASCII
        int          busy_cycles;  // UART_tx_busy held high for this many cycles from the ack cycle
        int          first_lat;    // cycles from ack to first start
        int          inject_at;    // 0 none, >0 second ack at that cycle, -1 in the final WAIT cycle
        logic [31:0] inj_word;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] o_data(input bit sel);
        return sel ? b2.UART_out_data : b8.UART_out_data;
    endfunction
    function automatic logic o_start(input bit sel);
        return sel ? b2.UART_tx_start : b8.UART_tx_start;
    endfunction
    function automatic logic o_busy(input bit sel);
        return sel ? b2.WB_o_busy : b8.WB_o_busy;
    endfunction
    function automatic logic o_ovr(input bit sel);
        return sel ? b2.WB_o_overrun : b8.WB_o_overrun;
    endfunction

    task automatic drive(input bit sel, input logic ack, input logic [31:0] d, input logic bsy);
        if (sel) begin
            b2.WB_i_ack = ack; b2.WB_i_data = d; b2.UART_tx_busy = bsy;
        end else begin
            b8.WB_i_ack = ack; b8.WB_i_data = d; b8.UART_tx_busy = bsy;
        end
    endtask

    task automatic check_idle_outputs(input bit sel, input string tag);
        check($sformatf("%s_data", tag), 32'(o_data(sel)), 32'h0);
        check($sformatf("%s_start", tag), 32'(o_start(sel)), 32'h0);
        check($sformatf("%s_busy", tag), 32'(o_busy(sel)), 32'h0);
        check($sformatf("%s_ovr", tag), 32'(o_ovr(sel)), 32'h0);
    endtask

    // Issues one ack at the current negedge and follows the frame to its end.
    task automatic run_frame(input vec_t v, input int id);
        logic [7:0] exp_c[10];
        int n, got, last, k, ovr_cnt, extra;
        bit done;
        n = v.nib + TERM_N;
        for (int i = 0; i < v.nib; i++) exp_c[i] = v.hex[(v.nib-1-i)*8 +: 8];
`ifdef WB2UART_CRLF_EN
        exp_c[v.nib] = 8'h0d; exp_c[v.nib+1] = 8'h0a;
`else
        exp_c[v.nib] = 8'h20;
`endif
        drive(v.sel, 1'b1, v.word, v.busy_cycles > 0);
        got = 0; last = 0; k = 0; ovr_cnt = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            k++;
            drive(v.sel, 1'b0, 32'h0, k < v.busy_cycles);
            if (v.inject_at > 0 && k == v.inject_at)
                drive(v.sel, 1'b1, v.inj_word, k < v.busy_cycles);
            if (v.inject_at < 0 && got == n && k == last + 2)
                drive(v.sel, 1'b1, v.inj_word, 1'b0);
            if (o_ovr(v.sel)) ovr_cnt++;
            if (o_start(v.sel)) begin
                if (got >= n) begin
                    checks++; errors++;
                    $display("FAIL v%0d_extra_start: start at cycle %0d after %0d chars", id, k, n);
                end else begin
                    check($sformatf("v%0d_char%0d", id, got), 32'(o_data(v.sel)), 32'(exp_c[got]));
                    check($sformatf("v%0d_gap%0d", id, got), 32'(k - last),
                          32'((got == 0) ? v.first_lat : 3));
                    last = k;
                    got++;
                end
            end
            if (got == n && k == last + 3) begin
                check($sformatf("v%0d_busy_end", id), 32'(o_busy(v.sel)), 32'h0);
                done = 1;
            end else if (k > 300) begin
                checks++; errors++;
                $display("FAIL v%0d_timeout: got %0d chars expected %0d", id, got, n);
                done = 1;
            end else begin
                check($sformatf("v%0d_busy_k%0d", id, k), 32'(o_busy(v.sel)), 32'h1);
            end
        end
        drive(v.sel, 1'b0, 32'h0, 1'b0);
        check($sformatf("v%0d_overrun_cnt", id), 32'(ovr_cnt), 32'((v.inject_at != 0) ? 1 : 0));
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_start(v.sel) || o_busy(v.sel)) extra++;
        end
        check($sformatf("v%0d_idle_after", id), 32'(extra), 32'h0);
        check($sformatf("v%0d_data_hold", id), 32'(o_data(v.sel)), 32'(exp_c[n-1]));
    endtask

    initial begin
        int s, k, starts;
        vecs[0] = '{sel:1'b0, nib:8, word:32'h1234abcd, hex:"1234abcd", busy_cycles:0,
                    first_lat:2, inject_at:0, inj_word:32'h0};
        vecs[1] = '{sel:1'b0, nib:8, word:32'h00000000, hex:"00000000", busy_cycles:10,
                    first_lat:11, inject_at:0, inj_word:32'h0};
        vecs[2] = '{sel:1'b0, nib:8, word:32'h12345678, hex:"12345678", busy_cycles:0,
                    first_lat:2, inject_at:5, inj_word:32'hffffffff};
        vecs[3] = '{sel:1'b0, nib:8, word:32'hffffffff, hex:"ffffffff", busy_cycles:0,
                    first_lat:2, inject_at:-1, inj_word:32'h55555555};
        vecs[4] = '{sel:1'b0, nib:8, word:32'h9a5f0e61, hex:"9a5f0e61", busy_cycles:3,
                    first_lat:4, inject_at:0, inj_word:32'h0};
        vecs[5] = '{sel:1'b1, nib:2, word:32'hdeadbe9f, hex:"9f", busy_cycles:0,
                    first_lat:2, inject_at:0, inj_word:32'h0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check_idle_outputs(1'b0, "rst8");
        check_idle_outputs(1'b1, "rst2");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Reset during a frame: abort after the third start pulse.
        drive(1'b0, 1'b1, 32'h1234abcd, 1'b0);
        s = 0;
        k = 0;
        while (s < 3 && k < 50) begin
            @(negedge clk);
            k++;
            drive(1'b0, 1'b0, 32'h0, 1'b0);
            if (b8.UART_tx_start) s++;
        end
        check("abort_third_start_seen", 32'(s), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs(1'b0, "abort");
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (b8.UART_tx_start || b8.WB_o_busy) starts++;
        end
        check("abort_quiet", 32'(starts), 32'h0);
        run_frame(vecs[0], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
